// File: rtl/input_debouncer.sv
// input_debouncer
//   Turns a raw asynchronous level (push-button, external strobe) into a
//   clean clock-synchronous level. A flop synchronizer feeds a 4-state
//   stability FSM that only moves db_out after STABLE_CYCLES consecutive equal
//   synchronized samples.
//
//   Optional feature, macro DEBOUNCE_GLITCH_CNT_EN:
//     defined   -> glitch_cnt counts rejected transitions, saturating at 255.
//     undefined -> counter logic is not built and glitch_cnt reads 8'd0.
//
//   Synchronizer depth: the FSM state register is the last rank of the
//   SYNC_STAGES-deep synchronizer. The dedicated chain therefore holds
//   SYNC_STAGES-1 flops. As a result, db_out changes on edge
//   SYNC_STAGES+STABLE_CYCLES-1, counting the edge on which the first flop
//   captures the new level as edge 1.
//
//   Interface: there is no handshake. db_out is a registered level. busy is
//   decoded from the state register alone, and is high while a candidate
//   transition is being qualified.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    output logic       db_out,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    // Number of dedicated synchronizer flops ahead of the FSM register.
    localparam int SQ_W = SYNC_STAGES - 1;

    // Last dwell count before a candidate level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b10,
        CHECK_LO  = 2'b11
    } state_t;

    logic [SQ_W-1:0]  sync_q;
    logic             a_sync;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             glitch;

    // Synchronizer chain: shift the raw input in, clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else if (SQ_W == 1) begin
            sync_q <= a;
        end else begin
            sync_q <= {sync_q[SQ_W-2:0], a};
        end
    end

    // Only the synchronized sample reaches the FSM.
    assign a_sync = sync_q[SQ_W-1];

    // FSM state, dwell counter and the registered debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Next-state logic. A reversal during a check restarts qualification from
    // zero. The counter stops at CNT_LAST, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        glitch  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (a_sync) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK_HI: begin
                if (!a_sync) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!a_sync) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK_LO: begin
                if (a_sync) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // db_out is high in STABLE_HI and in CHECK_LO. Registering it from the
        // next state keeps it aligned with the state register.
        db_d = (state_d == STABLE_HI) || (state_d == CHECK_LO);
    end

    assign db_out = db_q;

    // busy decodes the state register only; a and a_sync play no part in it.
    assign busy = (state_q == CHECK_HI) || (state_q == CHECK_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // Saturating count of rejected transitions. Only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= 8'd0;
        end else if (glitch && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    // Without the feature, the glitch strobe has no consumer.
    logic unused_glitch;
    assign unused_glitch = glitch;
    assign glitch_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
//   Directed bench for input_debouncer with SYNC_STAGES=2 and STABLE_CYCLES=4.
//   Each check tracks the edge that first captures a new input level as edge 1.
//   The glitch_cnt expectation follows DEBOUNCE_GLITCH_CNT_EN, so the same
//   bench covers both builds.
module tb_input_debouncer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 3;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       reset;
    logic       a;
    logic       db_out;
    logic       busy;
    logic [7:0] glitch_cnt;

    always #5 clk = ~clk;

    input_debouncer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .db_out    (db_out),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    // scoreboard
    int         vectors    = 0;
    int         miscompares = 0;
    int         glitches   = 0;
    logic [1:0] exp_q[$];   // {db_out, busy} expected after each edge

    // Advance one rising edge, then settle 1 ns before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_glitch(input int n);
        if (!GC_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // Apply one edge and compare db_out/busy with the head of exp_q.
    task automatic step_and_pop(input string tag);
        logic [1:0] e;
        tick();
        e = exp_q.pop_front();
        check({tag, "_db"},   {7'd0, db_out}, {7'd0, e[1]});
        check({tag, "_busy"}, {7'd0, busy},   {7'd0, e[0]});
    endtask

    // Drive one short pulse: a is high for two captures, then low.
    // This enters CHECK_HI and reverses there.
    task automatic glitch_pulse(input string tag);
        a = 1'b1;
        tick();                                    // edge 1: first flop captures 1
        tick();                                    // edge 2: CHECK_HI
        check({tag, "_busy"}, {7'd0, busy}, 8'd1);
        a = 1'b0;
        tick();                                    // edge 3: counter 2
        tick();                                    // edge 4: reversal seen -> STABLE_LO
        glitches++;
        check({tag, "_db"},  {7'd0, db_out}, 8'd0);
        check({tag, "_idle"}, {7'd0, busy},  8'd0);
        tick();
    endtask

    initial begin
        // reset: three cycles with a=0
        reset = 1'b1;
        a     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_db",   {7'd0, db_out}, 8'd0);
            check("rst_busy", {7'd0, busy},   8'd0);
            check("rst_gc",   glitch_cnt,     8'd0);
        end
        reset = 1'b0;
        tick();
        check("rel_db",   {7'd0, db_out}, 8'd0);
        check("rel_busy", {7'd0, busy},   8'd0);
        check("rel_gc",   glitch_cnt,     8'd0);

        // rise: db_out must go high exactly after edge 5
        a = 1'b1;
        exp_q = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        for (int e = 1; e <= 7; e++) step_and_pop($sformatf("rise_e%0d", e));

        // fall: the mirror path, db_out low exactly after edge 5
        a = 1'b0;
        exp_q = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
        for (int e = 1; e <= 7; e++) step_and_pop($sformatf("fall_e%0d", e));

        // A reversal during CHECK_LO from STABLE_HI must not move db_out.
        a = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("hi_again_db", {7'd0, db_out}, 8'd1);
        a = 1'b0;
        tick();
        tick();
        check("chk_lo_busy", {7'd0, busy},   8'd1);
        check("chk_lo_db",   {7'd0, db_out}, 8'd1);
        a = 1'b1;
        tick();
        tick();
        glitches++;
        check("lo_glitch_db",   {7'd0, db_out}, 8'd1);
        check("lo_glitch_busy", {7'd0, busy},   8'd0);
        check("lo_glitch_gc",   glitch_cnt,     exp_glitch(glitches));
        // Return to low cleanly.
        a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("back_lo_db", {7'd0, db_out}, 8'd0);

        // Single short pulse from STABLE_LO.
        glitch_pulse("glitch1");
        check("glitch1_gc", glitch_cnt, exp_glitch(glitches));

        // Repeat the pulse up to 300 more times; the counter saturates without wrapping.
        for (int i = 0; i < 300; i++) begin
            glitch_pulse("glitch_rep");
            if (glitches == 255) check("gc_at_255", glitch_cnt, exp_glitch(glitches));
        end
        check("gc_saturated", glitch_cnt, exp_glitch(glitches));
        check("gc_db_still_lo", {7'd0, db_out}, 8'd0);

        // Assert reset mid-qualification, while in CHECK_HI with counter 2.
        a = 1'b1;
        tick();                      // edge 1
        tick();                      // edge 2: CHECK_HI, counter 1
        tick();                      // edge 3: counter 2
        check("pre_rst_busy", {7'd0, busy}, 8'd1);
        reset = 1'b1;
        tick();
        check("midrst_db",   {7'd0, db_out}, 8'd0);
        check("midrst_busy", {7'd0, busy},   8'd0);
        check("midrst_gc",   glitch_cnt,     8'd0);
        reset = 1'b0;
        // With a still high, a full 5-edge qualification restarts.
        exp_q = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        for (int e = 1; e <= 6; e++) step_and_pop($sformatf("requal_e%0d", e));
        check("requal_gc", glitch_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Upper bound on run time, in case the sequence above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
